// File: rtl/mem_arbiter.sv
// Two-client memory bus arbiter: dcache priority with icache anti-starvation,
// outstanding-tag ownership tracking and return-data routing.
module mem_arbiter #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [1:0]      proc2Imem_command,
  input  logic [XLEN-1:0] proc2Imem_addr,
  input  logic [1:0]      proc2Dmem_command,
  input  logic [XLEN-1:0] proc2Dmem_addr,
  input  logic [63:0]     proc2Dmem_data,
  input  logic [3:0]      mem2proc_response,
  input  logic [63:0]     mem2proc_data,
  input  logic [3:0]      mem2proc_tag,
  output logic [1:0]      proc2mem_command,
  output logic [XLEN-1:0] proc2mem_addr,
  output logic [63:0]     proc2mem_data,
  output logic            d_request,
  output logic [3:0]      Imem2proc_response,
  output logic [63:0]     Imem2proc_data,
  output logic [3:0]      Imem2proc_tag,
  output logic [3:0]      Dmem2proc_response,
  output logic [63:0]     Dmem2proc_data,
  output logic [3:0]      Dmem2proc_tag,
  output logic            tag_conflict
);

  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam logic [1:0] BUS_LOAD = 2'd1;

  logic [15:1] valid_q, valid_d;
  logic [15:1] owner_q, owner_d;
  logic [3:0]  starve_q, starve_d;
  logic        conflict_q, conflict_d;

  logic i_req, d_req, force_i;
  logic grant_i, grant_d;
  logic ret_hit, ret_owner;
  logic alloc;

  assign i_req   = (proc2Imem_command != BUS_NONE);
  assign d_req   = (proc2Dmem_command != BUS_NONE);
  assign force_i = i_req & (int'(starve_q) >= STARVE_LIMIT);
  assign grant_d = d_req & ~force_i;
  assign grant_i = i_req & ~grant_d;

  always_comb begin
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    unique case (1'b1)
      grant_d: begin
        proc2mem_command = proc2Dmem_command;
        proc2mem_addr    = proc2Dmem_addr;
        proc2mem_data    = proc2Dmem_data;
      end
      grant_i: begin
        proc2mem_command = proc2Imem_command;
        proc2mem_addr    = proc2Imem_addr;
      end
      default: ;
    endcase
  end

  assign d_request          = grant_d;
  assign Imem2proc_response = grant_i ? mem2proc_response : 4'd0;
  assign Dmem2proc_response = grant_d ? mem2proc_response : 4'd0;
  assign alloc = (mem2proc_response != 4'd0) &&
                 (proc2mem_command == BUS_LOAD);

  // Owner lookup for the returning tag (tag 0 matches no entry)
  always_comb begin
    ret_hit   = 1'b0;
    ret_owner = 1'b0;
    for (int t = 1; t < 16; t++) begin
      if (mem2proc_tag == 4'(t)) begin
        ret_hit   = valid_q[t];
        ret_owner = owner_q[t];
      end
    end
  end

  always_comb begin
    Imem2proc_tag  = 4'd0;
    Imem2proc_data = '0;
    Dmem2proc_tag  = 4'd0;
    Dmem2proc_data = '0;
    if (ret_hit) begin
      if (ret_owner) begin
        Dmem2proc_tag  = mem2proc_tag;
        Dmem2proc_data = mem2proc_data;
      end else begin
        Imem2proc_tag  = mem2proc_tag;
        Imem2proc_data = mem2proc_data;
      end
    end
  end

  // Clear happens before allocate so a same-tag reallocation wins
  always_comb begin
    valid_d    = valid_q;
    owner_d    = owner_q;
    conflict_d = conflict_q;
    if (mem2proc_tag != 4'd0 && !ret_hit)
      conflict_d = 1'b1;
    for (int t = 1; t < 16; t++) begin
      if (ret_hit && mem2proc_tag == 4'(t))
        valid_d[t] = 1'b0;
    end
    for (int t = 1; t < 16; t++) begin
      if (alloc && mem2proc_response == 4'(t)) begin
        if (valid_d[t])
          conflict_d = 1'b1;
        valid_d[t] = 1'b1;
        owner_d[t] = grant_d;
      end
    end
  end

  always_comb begin
    starve_d = 4'd0;
    if (i_req && !grant_i)
      starve_d = (starve_q == 4'd15) ? 4'd15 : starve_q + 4'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q    <= '0;
      owner_q    <= '0;
      starve_q   <= 4'd0;
      conflict_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      owner_q    <= owner_d;
      starve_q   <= starve_d;
      conflict_q <= conflict_d;
    end
  end

  assign tag_conflict = conflict_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios then random traffic,
// checked against a tag-ownership reference model.
module tb_mem_arbiter;

  localparam int XLEN  = 32;
  localparam int LIMIT = 8;

  logic            clock = 1'b0;
  logic            reset;
  logic [1:0]      ic_cmd, dc_cmd;
  logic [XLEN-1:0] ic_addr, dc_addr;
  logic [63:0]     dc_data;
  logic [3:0]      m_resp, m_tag;
  logic [63:0]     m_data;
  logic [1:0]      p_cmd;
  logic [XLEN-1:0] p_addr;
  logic [63:0]     p_data;
  logic            d_req_o;
  logic [3:0]      i_resp, i_tag, d_resp, d_tag;
  logic [63:0]     i_data, d_data;
  logic            conf_o;

  mem_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIMIT)) dut (
    .clock(clock), .reset(reset),
    .proc2Imem_command(ic_cmd), .proc2Imem_addr(ic_addr),
    .proc2Dmem_command(dc_cmd), .proc2Dmem_addr(dc_addr),
    .proc2Dmem_data(dc_data),
    .mem2proc_response(m_resp), .mem2proc_data(m_data),
    .mem2proc_tag(m_tag),
    .proc2mem_command(p_cmd), .proc2mem_addr(p_addr),
    .proc2mem_data(p_data), .d_request(d_req_o),
    .Imem2proc_response(i_resp), .Imem2proc_data(i_data),
    .Imem2proc_tag(i_tag),
    .Dmem2proc_response(d_resp), .Dmem2proc_data(d_data),
    .Dmem2proc_tag(d_tag), .tag_conflict(conf_o)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  cmd;
    logic [31:0] addr;
    logic [63:0] data;
    logic        dreq;
    logic [3:0]  iresp, itag, dresp, dtag;
    logic [63:0] idata, ddata;
    logic        conf;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference model: owner[t] = -1 free, 0 icache, 1 dcache
  int owner[16];
  int starve;
  bit conf;

  function automatic void model_clear();
    for (int t = 0; t < 16; t++) owner[t] = -1;
    starve = 0;
    conf = 1'b0;
  endfunction

  task automatic chk(input string n, input logic [63:0] a,
                     input logic [63:0] e);
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h expected %h", n, $time, a, e);
    end
  endtask

  always @(negedge clock) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      vectors++;
      chk("cmd", 64'(p_cmd), 64'(e.cmd));
      chk("addr", 64'(p_addr), 64'(e.addr));
      chk("wdata", p_data, e.data);
      chk("d_request", 64'(d_req_o), 64'(e.dreq));
      chk("i_resp", 64'(i_resp), 64'(e.iresp));
      chk("d_resp", 64'(d_resp), 64'(e.dresp));
      chk("i_tag", 64'(i_tag), 64'(e.itag));
      chk("d_tag", 64'(d_tag), 64'(e.dtag));
      chk("i_data", i_data, e.idata);
      chk("d_data", d_data, e.ddata);
      chk("tag_conflict", 64'(conf_o), 64'(e.conf));
    end
  end

  task automatic cyc(input logic r, input logic [1:0] ic,
                     input logic [31:0] ia, input logic [1:0] dc,
                     input logic [31:0] da, input logic [63:0] dd,
                     input logic [3:0] resp, input logic [3:0] rt,
                     input logic [63:0] rd);
    exp_t e;
    bit ir, dr, gi, gd;
    int own;
    @(posedge clock);
    #1;
    reset = r; ic_cmd = ic; ic_addr = ia;
    dc_cmd = dc; dc_addr = da; dc_data = dd;
    m_resp = resp; m_tag = rt; m_data = rd;
    if (r) model_clear();
    ir = (ic != 0);
    dr = (dc != 0);
    gd = dr && !(ir && starve >= LIMIT);
    gi = ir && !gd;
    e.cmd  = gd ? dc : (gi ? ic : 2'd0);
    e.addr = gd ? da : (gi ? ia : 32'd0);
    e.data = gd ? dd : 64'd0;
    e.dreq = gd;
    e.iresp = gi ? resp : 4'd0;
    e.dresp = gd ? resp : 4'd0;
    own = (rt != 0) ? owner[rt] : -1;
    e.itag  = (own == 0) ? rt : 4'd0;
    e.idata = (own == 0) ? rd : 64'd0;
    e.dtag  = (own == 1) ? rt : 4'd0;
    e.ddata = (own == 1) ? rd : 64'd0;
    e.conf = conf;
    q.push_back(e);
    if (!r) begin
      if (rt != 0) begin
        if (own < 0) conf = 1'b1;
        else owner[rt] = -1;
      end
      if (resp != 0 && e.cmd == 2'd1) begin
        if (owner[resp] >= 0) conf = 1'b1;
        owner[resp] = gd ? 1 : 0;
      end
      starve = (ir && !gi) ? ((starve < 15) ? starve + 1 : 15) : 0;
    end
  endtask

  task automatic idle(input logic [3:0] rt, input logic [63:0] rd);
    cyc(1'b0, 2'd0, 0, 2'd0, 0, 0, 4'd0, rt, rd);
  endtask

  initial begin
    reset = 1'b1;
    ic_cmd = 0; ic_addr = 0; dc_cmd = 0; dc_addr = 0; dc_data = 0;
    m_resp = 0; m_tag = 0; m_data = 0;
    model_clear();
    cyc(1'b1, 2'd0, 0, 2'd0, 0, 0, 4'd0, 4'd0, 0);
    cyc(1'b1, 2'd0, 0, 2'd0, 0, 0, 4'd0, 4'd0, 0);
    // Icache load, tag 3, return two cycles later
    cyc(1'b0, 2'd1, 32'h100, 2'd0, 0, 0, 4'd3, 4'd0, 0);
    idle(4'd0, 0);
    idle(4'd3, 64'hDEADBEEF_00000013);
    idle(4'd0, 0);
    // Simultaneous loads: dcache wins tag 5
    cyc(1'b0, 2'd1, 32'h200, 2'd1, 32'h300, 64'h55, 4'd5, 4'd0, 0);
    idle(4'd5, 64'h0123_4567_89AB_CDEF);
    // Starvation: icache forced through after LIMIT denials
    for (int k = 0; k < 2 * LIMIT + 3; k++)
      cyc(1'b0, 2'd1, 32'h400, 2'd1, 32'h500 + k, 64'(k), 4'd0, 4'd0, 0);
    // Same-cycle clear and reallocate of tag 4
    cyc(1'b0, 2'd1, 32'h600, 2'd0, 0, 0, 4'd4, 4'd0, 0);
    cyc(1'b0, 2'd0, 0, 2'd1, 32'h700, 0, 4'd4, 4'd4, 64'hAAAA);
    idle(4'd4, 64'hBBBB);
    idle(4'd0, 0);
    // Store allocates nothing; stray return sets sticky conflict
    cyc(1'b0, 2'd0, 0, 2'd2, 32'h800, 64'hCAFE, 4'd7, 4'd0, 0);
    idle(4'd7, 64'h7777);
    idle(4'd0, 0);
    idle(4'd0, 0);
    // Mid-cycle reset with tags 2 and 9 outstanding
    cyc(1'b0, 2'd1, 32'h900, 2'd0, 0, 0, 4'd2, 4'd0, 0);
    cyc(1'b0, 2'd0, 0, 2'd1, 32'hA00, 0, 4'd9, 4'd0, 0);
    cyc(1'b1, 2'd0, 0, 2'd0, 0, 0, 4'd0, 4'd2, 64'h2222);
    idle(4'd9, 64'h9999);
    idle(4'd0, 0);
    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      logic [1:0] ic, dc;
      logic [3:0] resp, rt;
      int vt[$];
      int p;
      ic = ($urandom_range(0, 9) < 6) ? 2'd1 : 2'd0;
      p = $urandom_range(0, 9);
      dc = (p < 4) ? 2'd1 : ((p < 6) ? 2'd2 : 2'd0);
      resp = 4'd0;
      if ((ic != 0 || dc != 0) && $urandom_range(0, 9) < 7)
        resp = 4'($urandom_range(1, 15));
      vt.delete();
      for (int t = 1; t < 16; t++) if (owner[t] >= 0) vt.push_back(t);
      rt = 4'd0;
      p = $urandom_range(0, 99);
      if (p < 45 && vt.size() > 0)
        rt = 4'(vt[$urandom_range(0, vt.size() - 1)]);
      else if (p < 50)
        rt = 4'($urandom_range(1, 15));
      cyc(($urandom_range(0, 299) == 0), ic, $urandom, dc, $urandom,
          {$urandom, $urandom}, resp, rt, {$urandom, $urandom});
    end
    idle(4'd0, 0);
    repeat (3) @(posedge clock);
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d pending, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-client arbiter between the instruction cache and the data cache on one side and the single-ported main-memory bus on the other.
- Grants at most one bus command per cycle, with data-cache priority and an anti-starvation override for the instruction cache.
- Records which client owns each outstanding 4-bit memory transaction tag.
- Routes returning data and tags only to the owning client.
- Drives the `d_request` signal that tells the instruction cache its bus command was not taken this cycle.

Parameters:
- XLEN, 32, address width.
- STARVE_LIMIT, 8, consecutive denied icache cycles before the icache is forced to win one cycle (legal range 1..15).

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high
- proc2Imem_command  input  2  icache command (BUS_NONE=0, BUS_LOAD=1; BUS_STORE=2 never issued)
- proc2Imem_addr  input  XLEN  icache address
- proc2Dmem_command  input  2  dcache command (BUS_NONE, BUS_LOAD, BUS_STORE)
- proc2Dmem_addr  input  XLEN  dcache address
- proc2Dmem_data  input  64  dcache store data
- mem2proc_response  input  4  memory accept tag; 0 = rejected
- mem2proc_data  input  64  memory return data
- mem2proc_tag  input  4  memory return tag; 0 = no return
- proc2mem_command  output  2  command to memory
- proc2mem_addr  output  XLEN  address to memory
- proc2mem_data  output  64  store data to memory
- d_request  output  1  1 = dcache holds the bus this cycle (icache command not taken)
- Imem2proc_response  output  4  accept tag to icache
- Imem2proc_data  output  64  return data to icache
- Imem2proc_tag  output  4  return tag to icache
- Dmem2proc_response  output  4  accept tag to dcache
- Dmem2proc_data  output  64  return data to dcache
- Dmem2proc_tag  output  4  return tag to dcache
- tag_conflict  output  1  sticky error flag

Behaviour:
- Grant is combinational, zero latency.
  - `i_req = (proc2Imem_command != BUS_NONE)`; `d_req` is defined the same way on the dcache command.
  - `force_i = i_req & (starve_cnt >= STARVE_LIMIT)`.
  - `grant_d = d_req & ~force_i`; `grant_i = i_req & ~grant_d`.
- Bus mux:
  - `proc2mem_*` carries the granted client's command, address and data.
  - With no grant, command is BUS_NONE, address 0, data 0.
  - Icache data is always driven as 0.
- `d_request = grant_d`.
- Accept tags:
  - `Imem2proc_response = grant_i ? mem2proc_response : 0`.
  - `Dmem2proc_response = grant_d ? mem2proc_response : 0`.
- Owner table:
  - 15 entries indexed by tags 1..15, each holding `{valid, owner}` with owner 0 = I, 1 = D.
  - Allocate on nonzero `mem2proc_response` with a BUS_LOAD granted: set `valid[resp]` and record `owner[resp]`.
  - Accepted stores allocate nothing.
- Return routing:
  - When `mem2proc_tag != 0` and `valid[tag]`, forward `mem2proc_tag` and `mem2proc_data` to the owner's `*_tag` and `*_data` outputs.
  - The other client sees tag 0 and data 0.
  - Clear `valid[tag]` at the next clock edge.
  - A return tag with the entry invalid goes to no client (both tags 0) and sets `tag_conflict`.
- Same-cycle clear and allocate of the same tag: the allocate wins, so the entry ends valid with the new owner. The return is still routed using the old owner.
- Allocating onto an entry that is already valid (with no same-cycle clear): overwrite the entry and set `tag_conflict`.
- Starvation counter (`starve_cnt`, 4-bit, saturating at 15):
  - Increment when `i_req & ~grant_i`.
  - Reset to 0 when `grant_i` or `~i_req`.
- `tag_conflict` stays set until reset.
- Reset (asynchronous, takes effect immediately and mid-transaction):
  - All `valid` bits, `starve_cnt` and `tag_conflict` clear to 0.
  - Outputs are then purely the combinational function of the inputs; with idle inputs every output is 0.
  - Memory returns for tags issued before reset are treated as unowned.
  - Such a return sets `tag_conflict` only if it arrives after reset deasserts.
- Timing paths: no combinational path from `mem2proc_*` to `proc2mem_*`. Outputs routed from `mem2proc_*` are combinational through the owner table.

Test Plan:
1. Icache alone issues BUS_LOAD to 0x100; memory responds 3, then two cycles later returns tag 3 with data 0xDEADBEEF_00000013 -> `Imem2proc_response=3`, then `Imem2proc_tag=3` with that data; `Dmem2proc_tag=0` throughout; `valid[3]` ends 0.
2. Both clients issue loads in the same cycle, response 5 -> `proc2mem_addr` is the dcache address; `d_request=1`; `Dmem2proc_response=5`; `Imem2proc_response=0`; tag 5 return goes only to the dcache.
3. Dcache issues loads continuously while the icache holds a load -> icache denied 8 cycles; in the 9th cycle `grant_i=1`, `d_request=0`, `starve_cnt` returns to 0.
4. Dcache BUS_STORE accepted with response 7, then a stray return with tag 7 -> no allocation; both return tags 0; `tag_conflict=1` and stays 1.
5. Same cycle: return of tag 4 (owner I) and a new dcache load accepted with tag 4 -> icache receives tag 4; `owner[4]=D`, `valid[4]=1` afterwards; `tag_conflict` stays 0.
6. Reset asserted mid-cycle with tags 2 and 9 outstanding -> `valid` clears without waiting for a clock edge; after deassert, a return of tag 9 reaches neither client and sets `tag_conflict`.
